sequence_detector_param_moore: RTL

//  Parametrised Moore serial-pattern detector. It is the generalised successor to the fixed
//  4-bit detectors in the FSM library.
//  - Detects a runtime-programmable SEQ_LEN-bit pattern on a 1-bit stream qualified by din_valid.
//  - Overlap or non-overlap matching is selected at runtime.
//  - Counts matches in a saturating counter.
//  - Used as a standalone stream monitor or as a framing/sync-word detector ahead of

---
 rtl/sequence_detector_param_moore.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sequence_detector_param_moore.sv
// Parametrised Moore serial-pattern detector.
// The state is the length of the pattern prefix currently matched (0..SEQ_LEN).
// Each consumed bit runs a KMP-style search over the recent history, so fallback
// after a mismatch lands on the longest prefix that is still alive.
// Overlap or non-overlap matching is selected at runtime.
// Matches are counted in a saturating counter.
module sequence_detector_param_moore #(
  parameter int unsigned          SEQ_LEN     = 4,
  parameter logic [SEQ_LEN-1:0]   RST_PATTERN = 4'b1101,
  parameter logic                 RST_OVERLAP = 1'b0,
  parameter int unsigned          CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [SEQ_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               dout,
  output logic               busy,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int unsigned      SW      = $clog2(SEQ_LEN + 1);
  localparam logic [SW-1:0]    FULL    = SW'(SEQ_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SW-1:0]      state_r;
  logic [SW-1:0]      next_s;
  logic [SEQ_LEN-2:0] hist_r;
  logic [SEQ_LEN-1:0] pat_r;
  logic               ovl_r;
  logic               dout_r;
  logic               busy_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic [SEQ_LEN-1:0] window_s;
  logic               consume_s;
  int unsigned        lim_s;

  // True when the newest k bits of the window (window[k-1] oldest) equal the
  // first k pattern bits (pattern[SEQ_LEN-1] is received first). Shifting both
  // operands to the top of the vector avoids variable part-selects.
  function automatic logic prefix_match(input logic [SEQ_LEN-1:0] window,
                                        input logic [SEQ_LEN-1:0] pattern,
                                        input int unsigned        k);
    logic [SEQ_LEN-1:0] mask;
    logic [SEQ_LEN-1:0] aligned;
    mask    = {SEQ_LEN{1'b1}} << (SEQ_LEN - k);
    aligned = window << (SEQ_LEN - k);
    return ((aligned ^ pattern) & mask) == {SEQ_LEN{1'b0}};
  endfunction

  // Next prefix length: the longest pattern prefix that ends at the incoming bit,
  // bounded by one more than the usable current length.
  always_comb begin
    window_s  = {hist_r, din};
    consume_s = din_valid & ~cfg_load;
    next_s    = {SW{1'b0}};
    if ((state_r == FULL) && !ovl_r) begin
      lim_s = 32'd1;
    end else begin
      lim_s = 32'(state_r) + 32'd1;
    end
    if (lim_s > SEQ_LEN) begin
      lim_s = SEQ_LEN;
    end else begin
      lim_s = lim_s;
    end
    for (int unsigned k = 1; k <= SEQ_LEN; k++) begin
      if ((k <= lim_s) && prefix_match(window_s, pat_r, k)) begin
        next_s = SW'(k);
      end else begin
        next_s = next_s;
      end
    end
  end

  // Next match count: clear beats a coincident match; saturates instead of wrapping.
  always_comb begin
    cnt_next_s = cnt_r;
    if (cnt_clr) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (consume_s && (next_s == FULL) && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Detector state, history and configuration. Flags are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= {SW{1'b0}};
      hist_r  <= {(SEQ_LEN-1){1'b0}};
      pat_r   <= RST_PATTERN;
      ovl_r   <= RST_OVERLAP;
      dout_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else if (cfg_load) begin
      state_r <= {SW{1'b0}};
      hist_r  <= {(SEQ_LEN-1){1'b0}};
      pat_r   <= cfg_pattern;
      ovl_r   <= cfg_overlap;
      dout_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else if (din_valid) begin
      state_r <= next_s;
      hist_r  <= window_s[SEQ_LEN-2:0];
      dout_r  <= (next_s == FULL);
      busy_r  <= (next_s != {SW{1'b0}}) && (next_s != FULL);
    end else begin
      state_r <= state_r;
      hist_r  <= hist_r;
      dout_r  <= dout_r;
      busy_r  <= busy_r;
    end
  end

  // Saturating match counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign dout      = dout_r;
  assign busy      = busy_r;
  assign match_cnt = cnt_r;

endmodule
